// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
// The perf counter signals exist only when STALL_PERF_CNT_EN is defined.
interface pipeline_ctrl_if
`ifdef STALL_PERF_CNT_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        exc_req;
    logic        wdt_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_cyc;
    logic [CNT_W-1:0] perf_flush_cnt;
`endif

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, exc_req, wdt_clr,
`ifdef STALL_PERF_CNT_EN
        input  perf_stall_cyc, perf_flush_cnt,
`endif
        input  stall, flush, new_pc, stall_timeout
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, exc_req, wdt_clr,
`ifdef STALL_PERF_CNT_EN
        output perf_stall_cyc, perf_flush_cnt,
`endif
        output stall, flush, new_pc, stall_timeout
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: merges stage stall requests, sequences exception redirects
// and runs a stall watchdog. Optional perf counters are enabled by STALL_PERF_CNT_EN.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h00000020,
    parameter int          STALL_TIMEOUT = 64
`ifdef STALL_PERF_CNT_EN
    ,
    parameter int          CNT_W         = 32
`endif
) (
    input  logic             Clk,
    input  logic             Rst,
    pipeline_ctrl_if.slave   pc
);
    localparam int              CW       = $clog2(STALL_TIMEOUT) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(STALL_TIMEOUT - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           timeout_q, timeout_d;
    logic           flush_q, flush_d;
    logic [31:0]    new_pc_q, new_pc_d;
    logic [5:0]     stall_s;
    logic [5:0]     stall_out_s;
    logic           any_req_s;

    assign any_req_s = pc.stallreq_id | pc.stallreq_ex | pc.stallreq_mem;

    // Next-state, watchdog counter and same-cycle stall vector.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        stall_s   = 6'b000000;
        case (state_q)
            RUN: begin
                if (pc.exc_req) begin
                    stall_s = 6'b111111;
                    state_d = FLUSH;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    if (pc.stallreq_mem) begin
                        stall_s = 6'b011111;
                    end else if (pc.stallreq_ex) begin
                        stall_s = 6'b001111;
                    end else if (pc.stallreq_id) begin
                        stall_s = 6'b000111;
                    end else begin
                        stall_s = 6'b000000;
                    end
                    // Counter is held at its last value once HALT is entered, so it never wraps.
                    if (any_req_s) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d   = HALT;
                            timeout_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d = {CW{1'b0}};
                    end
                end
            end
            FLUSH: begin
                state_d = RUN;
                cnt_d   = {CW{1'b0}};
            end
            HALT: begin
                stall_s = 6'b111111;
                if (pc.wdt_clr) begin
                    state_d   = RUN;
                    timeout_d = 1'b0;
                    cnt_d     = {CW{1'b0}};
                end else begin
                    state_d = HALT;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = {CW{1'b0}};
            end
        endcase

        if (Rst) begin
            stall_out_s = 6'b000000;
        end else begin
            stall_out_s = stall_s;
        end

        flush_d  = (state_d == FLUSH);
        if (state_d == FLUSH) begin
            new_pc_d = EXC_VECTOR;
        end else begin
            new_pc_d = 32'h00000000;
        end
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= RUN;
            cnt_q     <= {CW{1'b0}};
            timeout_q <= 1'b0;
            flush_q   <= 1'b0;
            new_pc_q  <= 32'h00000000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            flush_q   <= flush_d;
            new_pc_q  <= new_pc_d;
        end
    end

    assign pc.stall         = stall_out_s;
    assign pc.flush         = flush_q;
    assign pc.new_pc        = new_pc_q;
    assign pc.stall_timeout = timeout_q;

`ifdef STALL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] PERF_ONE = CNT_W'(1);

    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

    // Saturating perf counters.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if ((stall_out_s != 6'b000000) && (perf_stall_q != {CNT_W{1'b1}})) begin
            perf_stall_d = perf_stall_q + PERF_ONE;
        end else begin
            perf_stall_d = perf_stall_q;
        end
        if ((state_q == FLUSH) && (perf_flush_q != {CNT_W{1'b1}})) begin
            perf_flush_d = perf_flush_q + PERF_ONE;
        end else begin
            perf_flush_d = perf_flush_q;
        end
    end

    // Perf counter registers, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            perf_stall_q <= {CNT_W{1'b0}};
            perf_flush_q <= {CNT_W{1'b0}};
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign pc.perf_stall_cyc = perf_stall_q;
    assign pc.perf_flush_cnt = perf_flush_q;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random traffic,
// compared every cycle against a cycle-count based behavioural model.
module tb_pipeline_ctrl;
    localparam int          T     = 8;
    localparam logic [31:0] EXC   = 32'h00000020;
`ifdef STALL_PERF_CNT_EN
    localparam int          CW    = 4;
    localparam int          PMAX  = (1 << CW) - 1;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

`ifdef STALL_PERF_CNT_EN
    pipeline_ctrl_if #(.CNT_W(CW)) bus ();
    pipeline_ctrl #(.EXC_VECTOR(EXC), .STALL_TIMEOUT(T), .CNT_W(CW)) dut (
        .Clk(Clk), .Rst(Rst), .pc(bus));
`else
    pipeline_ctrl_if bus ();
    pipeline_ctrl #(.EXC_VECTOR(EXC), .STALL_TIMEOUT(T)) dut (
        .Clk(Clk), .Rst(Rst), .pc(bus));
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model: pending flush, halted flag, consecutive stalled-cycle run length.
    bit m_flush_pend = 1'b0;
    bit m_halted     = 1'b0;
    int m_run        = 0;
`ifdef STALL_PERF_CNT_EN
    int m_perf_s = 0;
    int m_perf_f = 0;
`endif

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] exp_stall(bit rst, bit fl, bit hl, bit exc, bit id, bit ex, bit mem);
        if (rst || fl) return 6'b000000;
        if (hl || exc) return 6'b111111;
        if (mem) return 6'b011111;
        if (ex) return 6'b001111;
        if (id) return 6'b000111;
        return 6'b000000;
    endfunction

    always @(negedge Clk) begin
        if (chk_en) begin
            logic [5:0] es;
            es = exp_stall(Rst, m_flush_pend, m_halted, bus.exc_req,
                           bus.stallreq_id, bus.stallreq_ex, bus.stallreq_mem);
            check("stall", {26'd0, bus.stall}, {26'd0, es});
            check("flush", {31'd0, bus.flush}, {31'd0, m_flush_pend});
            check("new_pc", bus.new_pc, m_flush_pend ? EXC : 32'h0);
            check("stall_timeout", {31'd0, bus.stall_timeout}, {31'd0, m_halted});
`ifdef STALL_PERF_CNT_EN
            check("perf_stall_cyc", {28'd0, bus.perf_stall_cyc}, m_perf_s);
            check("perf_flush_cnt", {28'd0, bus.perf_flush_cnt}, m_perf_f);
            if (Rst) begin
                m_perf_s = 0;
                m_perf_f = 0;
            end else begin
                if (es != 6'b0 && m_perf_s < PMAX) m_perf_s++;
                if (m_flush_pend && m_perf_f < PMAX) m_perf_f++;
            end
`endif
            if (Rst) begin
                m_flush_pend = 1'b0;
                m_halted     = 1'b0;
                m_run        = 0;
            end else if (m_flush_pend) begin
                m_flush_pend = 1'b0;
                m_run        = 0;
            end else if (m_halted) begin
                if (bus.wdt_clr) begin
                    m_halted = 1'b0;
                    m_run    = 0;
                end
            end else if (bus.exc_req) begin
                m_flush_pend = 1'b1;
                m_run        = 0;
            end else if (bus.stallreq_id || bus.stallreq_ex || bus.stallreq_mem) begin
                m_run++;
                if (m_run == T) m_halted = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    end

    task automatic step(bit id, bit ex, bit mem, bit exc, bit wclr, bit rst);
        @(posedge Clk);
        #1;
        bus.stallreq_id  = id;
        bus.stallreq_ex  = ex;
        bus.stallreq_mem = mem;
        bus.exc_req      = exc;
        bus.wdt_clr      = wclr;
        Rst              = rst;
        @(negedge Clk);
    endtask

    initial begin
        bus.stallreq_id  = 1'b1;
        bus.stallreq_ex  = 1'b1;
        bus.stallreq_mem = 1'b1;
        bus.exc_req      = 1'b0;
        bus.wdt_clr      = 1'b0;
        @(posedge Clk);
        #1 chk_en = 1'b1;
        @(negedge Clk);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("lit_rst_stall", {26'd0, bus.stall}, 32'h0);
        check("lit_rst_flush", {31'd0, bus.flush}, 32'h0);
        check("lit_rst_newpc", bus.new_pc, 32'h0);
        check("lit_rst_timeout", {31'd0, bus.stall_timeout}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check("lit_ex_stall", {26'd0, bus.stall}, 32'h0000000F);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_ex_release", {26'd0, bus.stall}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check("lit_ex_id_stall", {26'd0, bus.stall}, 32'h0000000F);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_id_stall", {26'd0, bus.stall}, 32'h00000007);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("lit_exc_freeze", {26'd0, bus.stall}, 32'h0000003F);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lit_exc_flush", {31'd0, bus.flush}, 32'h1);
        check("lit_exc_newpc", bus.new_pc, 32'h00000020);
        check("lit_exc_stall", {26'd0, bus.stall}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_exc_done", {31'd0, bus.flush}, 32'h0);

        for (int i = 0; i < T; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            check("lit_wdt_pre", {31'd0, bus.stall_timeout}, 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("lit_wdt_halt_stall", {26'd0, bus.stall}, 32'h0000003F);
            check("lit_wdt_flag", {31'd0, bus.stall_timeout}, 32'h1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("lit_wdt_clr_cycle", {26'd0, bus.stall}, 32'h0000003F);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_wdt_cleared", {31'd0, bus.stall_timeout}, 32'h0);
        check("lit_wdt_no_flush", {31'd0, bus.flush}, 32'h0);

        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("lit_rstflush_in", {31'd0, bus.flush}, 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_rstflush_out", {31'd0, bus.flush}, 32'h0);
        check("lit_rstflush_pc", bus.new_pc, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 199) == 0));
        end

`ifdef STALL_PERF_CNT_EN
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_perf_flush", {28'd0, bus.perf_flush_cnt}, 32'h2);
        check("lit_perf_stall_exc", {28'd0, bus.perf_stall_cyc}, 32'h2);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("lit_perf_sat", {28'd0, bus.perf_stall_cyc}, 32'hF);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
